// File: rtl/speechrec_pkg.sv
// Shared state encoding and SPI framing constants for the speech-recognition audio link.
package speechrec_pkg;

    localparam logic [1:0] SPI_MODE       = 2'd0;
    localparam logic       SCK_IDLE_LEVEL = SPI_MODE[1];

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RECEIVE   = 4'd1,
        PROCESS   = 4'd2,
        WAIT_TX   = 4'd3,
        TRANSMIT  = 4'd4,
        WAIT_ECHO = 4'd5,
        ECHO      = 4'd6,
        CHECK     = 4'd7
    } link_state_t;

endpackage

// File: rtl/spi_sync_shifter.sv
// Pin synchronisers, registered edge detection, bit counting and MSB-first word assembly
// for the SPI slave inputs.
module spi_sync_shifter
    import speechrec_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              sdi,
    input  logic              ss,
    input  logic              hold,
    output logic              sck_fall,
    output logic              ss_rise,
    output logic              ss_fall,
    output logic              word_done,
    output logic [WORD_W-1:0] rx_word
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int SCK   = 0;
    localparam int SDI   = 1;
    localparam int SS    = 2;
    // ss resets high so a frame already in progress when reset lifts never looks like a new frame
    localparam logic [2:0] PIN_RESET = {1'b1, 1'b0, SCK_IDLE_LEVEL};

    logic [2:0]        pin_meta_reg;
    logic [2:0]        pin_sync_reg;
    logic [2:0]        pin_prev_reg;
    logic              sck_rise_reg;
    logic              sck_fall_reg;
    logic              ss_rise_reg;
    logic              ss_fall_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [WORD_W-2:0] rx_reg;
    logic              bit_strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_meta_reg <= PIN_RESET;
            pin_sync_reg <= PIN_RESET;
            pin_prev_reg <= PIN_RESET;
            sck_rise_reg <= 1'b0;
            sck_fall_reg <= 1'b0;
            ss_rise_reg  <= 1'b0;
            ss_fall_reg  <= 1'b0;
        end else begin
            pin_meta_reg <= {ss, sdi, sck};
            pin_sync_reg <= pin_meta_reg;
            pin_prev_reg <= pin_sync_reg;
            sck_rise_reg <= pin_sync_reg[SCK] & ~pin_prev_reg[SCK];
            sck_fall_reg <= ~pin_sync_reg[SCK] & pin_prev_reg[SCK];
            ss_rise_reg  <= pin_sync_reg[SS] & ~pin_prev_reg[SS];
            ss_fall_reg  <= ~pin_sync_reg[SS] & pin_prev_reg[SS];
        end
    end

    // pin_prev_reg lines up sdi and the ss level with the registered edge pulses
    assign bit_strobe = sck_rise_reg & pin_prev_reg[SS] & ~hold & ~ss_fall_reg;
    assign word_done  = bit_strobe && (bit_cnt_reg == CNT_W'(WORD_W - 1));
    assign rx_word    = {rx_reg, pin_prev_reg[SDI]};
    assign sck_fall   = sck_fall_reg;
    assign ss_rise    = ss_rise_reg;
    assign ss_fall    = ss_fall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= '0;
            rx_reg      <= '0;
        end else if (hold || ss_fall_reg) begin
            bit_cnt_reg <= '0;
        end else if (bit_strobe) begin
            rx_reg      <= rx_word[WORD_W-2:0];
            bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spi_audio_link.sv
// SPI-slave audio link: stores N_SAMPLES words into sample memory, returns the matcher
// result to the master and verifies its echo with bounded retries.
module spi_audio_link
    import speechrec_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int SAMPLE_W  = 10,
    parameter int N_SAMPLES = 1000,
    parameter int MAX_RETRY = 3,
    parameter int ADDR_W    = $clog2(N_SAMPLES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sck,
    input  logic                sdi,
    input  logic                ss,
    output logic                sdo,
    input  logic [WORD_W-1:0]   result,
    input  logic                result_valid,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SAMPLE_W-1:0] wr_data,
    output logic                input_ready,
    output logic                confirmed,
    output logic                failed,
    output logic [3:0]          state
);

    localparam int CNT_W   = $clog2(N_SAMPLES + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    link_state_t         state_reg;
    link_state_t         state_next;
    logic [CNT_W-1:0]    sample_cnt_reg;
    logic [RETRY_W-1:0]  retry_cnt_reg;
    logic [WORD_W-1:0]   result_reg;
    logic [WORD_W-1:0]   tx_reg;
    logic                match_reg;
    logic                wr_en_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [SAMPLE_W-1:0] wr_data_reg;
    logic                input_ready_reg;
    logic                confirmed_reg;
    logic                failed_reg;

    logic                hold;
    logic                sck_fall;
    logic                ss_rise;
    logic                ss_fall;
    logic                word_done;
    logic [WORD_W-1:0]   rx_word;
    logic                last_sample;
    logic                retry_left;

    // Bit counting is frozen outside the two receiving states, except on the ss rise that opens one
    assign hold = !(state_reg == RECEIVE || state_reg == ECHO) && !ss_rise;

    spi_sync_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .sck       (sck),
        .sdi       (sdi),
        .ss        (ss),
        .hold      (hold),
        .sck_fall  (sck_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall),
        .word_done (word_done),
        .rx_word   (rx_word)
    );

    assign last_sample = (sample_cnt_reg == CNT_W'(N_SAMPLES - 1));
    assign retry_left  = (retry_cnt_reg < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (ss_rise) state_next = RECEIVE;
            RECEIVE:   if (word_done && last_sample) state_next = PROCESS;
            PROCESS:   if (result_valid) state_next = WAIT_TX;
            WAIT_TX:   if (ss_rise) state_next = TRANSMIT;
            TRANSMIT:  if (ss_fall) state_next = WAIT_ECHO;
            WAIT_ECHO: if (ss_rise) state_next = ECHO;
            ECHO:      if (word_done || ss_fall) state_next = CHECK;
            CHECK:     state_next = (!match_reg && retry_left) ? WAIT_TX : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt_reg  <= '0;
            retry_cnt_reg   <= '0;
            result_reg      <= '0;
            tx_reg          <= '0;
            match_reg       <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            input_ready_reg <= 1'b0;
            confirmed_reg   <= 1'b0;
            failed_reg      <= 1'b0;
        end else begin
            wr_en_reg     <= 1'b0;
            confirmed_reg <= 1'b0;
            failed_reg    <= 1'b0;
            if (state_next == IDLE) begin
                input_ready_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    sample_cnt_reg <= '0;
                    retry_cnt_reg  <= '0;
                end
                RECEIVE: begin
                    if (word_done) begin
                        wr_en_reg      <= 1'b1;
                        wr_addr_reg    <= sample_cnt_reg[ADDR_W-1:0];
                        wr_data_reg    <= rx_word[SAMPLE_W-1:0];
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                        if (last_sample) begin
                            input_ready_reg <= 1'b1;
                        end
                    end
                end
                PROCESS: begin
                    if (result_valid) begin
                        result_reg <= result;
                        tx_reg     <= result;
                    end
                end
                TRANSMIT: begin
                    // Reload on frame end so a retry starts again from the MSB
                    if (ss_fall) begin
                        tx_reg <= result_reg;
                    end else if (sck_fall) begin
                        tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
                    end
                end
                ECHO: begin
                    if (word_done) begin
                        match_reg <= (rx_word == result_reg);
                    end else if (ss_fall) begin
                        match_reg <= 1'b0;
                    end
                end
                CHECK: begin
                    if (match_reg) begin
                        confirmed_reg <= 1'b1;
                    end else if (retry_left) begin
                        retry_cnt_reg <= retry_cnt_reg + 1'b1;
                    end else begin
                        failed_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sdo         = (state_reg == WAIT_TX || state_reg == TRANSMIT) ? tx_reg[WORD_W-1] : 1'b0;
    assign wr_en       = wr_en_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;
    assign input_ready = input_ready_reg;
    assign confirmed   = confirmed_reg;
    assign failed      = failed_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_spi_audio_link.sv
// Directed bench for spi_audio_link: SPI master model, expected-write and outcome scoreboards.
module tb_spi_audio_link;

    localparam int WORD_W    = 32;
    localparam int SAMPLE_W  = 10;
    localparam int N_SAMPLES = 4;
    localparam int MAX_RETRY = 3;
    localparam int ADDR_W    = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sck = 1'b0;
    logic                sdi = 1'b0;
    logic                ss = 1'b0;
    logic [WORD_W-1:0]   result = '0;
    logic                result_valid = 1'b0;
    logic                sdo;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SAMPLE_W-1:0] wr_data;
    logic                input_ready;
    logic                confirmed;
    logic                failed;
    logic [3:0]          state;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [SAMPLE_W-1:0] data;
        logic                last;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    wr_t         exp_wr[$];
    int          exp_out[$];   // 1 = confirmed, 2 = failed
    wr_t         cmp_e;
    int          cmp_o;
    int          writes_seen = 0;
    int          conf_seen = 0;
    int          fail_seen = 0;
    int          frame_cnt = 0;
    int          retry_model = 0;
    logic [31:0] result_model = '0;
    logic [31:0] got;

    spi_audio_link #(
        .WORD_W    (WORD_W),
        .SAMPLE_W  (SAMPLE_W),
        .N_SAMPLES (N_SAMPLES),
        .MAX_RETRY (MAX_RETRY),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .sdi          (sdi),
        .ss           (ss),
        .sdo          (sdo),
        .result       (result),
        .result_valid (result_valid),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .input_ready  (input_ready),
        .confirmed    (confirmed),
        .failed       (failed),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        total++;
        if (actual !== want) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, actual, want);
        end
    endtask

    // Scoreboard: every write and every outcome pulse must match what the stimulus predicted
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                writes_seen++;
                $display("write addr=%0d data=%h input_ready=%0b", wr_addr, wr_data, input_ready);
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=addr%0d/%h required=none", wr_addr, wr_data);
                end else begin
                    cmp_e = exp_wr.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(cmp_e.addr));
                    check("wr_data", 32'(wr_data), 32'(cmp_e.data));
                    check("input_ready_at_write", 32'(input_ready), 32'(cmp_e.last));
                end
            end
            if (confirmed) conf_seen++;
            if (failed) fail_seen++;
            if (confirmed || failed) begin
                if (exp_out.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_outcome actual=%0b%0b required=none", confirmed, failed);
                end else begin
                    cmp_o = exp_out.pop_front();
                    check("outcome", {30'd0, confirmed, failed}, (cmp_o == 1) ? 32'd2 : 32'd1);
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] mosi, input int nbits, output logic [31:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = mosi[31-i];
            clks(8);
            sck = 1'b1;
            miso = {miso[30:0], sdo};
            clks(8);
            sck = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [31:0] mosi, input int nbits, output logic [31:0] miso);
        ss = 1'b1;
        clks(4);
        spi_bits(mosi, nbits, miso);
        clks(4);
        ss = 1'b0;
        sdi = 1'b0;
        clks(8);
    endtask

    task automatic start_frame();
        frame_cnt = 0;
        retry_model = 0;
    endtask

    task automatic push_write(input int addr, input logic [31:0] w);
        wr_t t;
        t.addr = ADDR_W'(addr);
        t.data = w[SAMPLE_W-1:0];
        t.last = (addr == N_SAMPLES - 1);
        exp_wr.push_back(t);
    endtask

    task automatic send_sample(input logic [31:0] w);
        logic [31:0] dummy;
        if (frame_cnt < N_SAMPLES) begin
            push_write(frame_cnt, w);
            frame_cnt++;
        end
        spi_xfer(w, 32, dummy);
    endtask

    task automatic load_result(input logic [31:0] r);
        result_model = r;
        result = r;
        result_valid = 1'b1;
        clks(2);
        result_valid = 1'b0;
        check("state_wait_tx", 32'(state), 32'd3);
        check("sdo_first_bit", 32'(sdo), 32'(r[31]));
    endtask

    task automatic exchange(input logic [31:0] echo, input int echo_bits);
        logic [31:0] tx_word;
        logic [31:0] dummy;
        int want;
        spi_xfer(32'h0, 32, tx_word);
        check("sdo_word", tx_word, result_model);
        if (echo_bits == 32 && echo == result_model) want = 1;
        else if (retry_model < MAX_RETRY) want = 0;
        else want = 2;
        if (want != 0) exp_out.push_back(want);
        else retry_model++;
        spi_xfer(echo, echo_bits, dummy);
        clks(6);
        check("state_after_echo", 32'(state), (want == 0) ? 32'd3 : 32'd0);
        $display("exchange tx=%h echo=%h bits=%0d outcome=%0d", tx_word, echo, echo_bits, want);
    endtask

    initial begin
        clks(3);
        check("reset_state", 32'(state), 32'd0);
        check("reset_sdo", 32'(sdo), 32'd0);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);
        check("reset_input_ready", 32'(input_ready), 32'd0);
        check("reset_confirmed", 32'(confirmed), 32'd0);
        check("reset_failed", 32'(failed), 32'd0);
        reset = 1'b0;
        clks(8);

        // Frame 1: aborted partial word, saturation, single confirmed exchange
        start_frame();
        ss = 1'b1;
        clks(4);
        spi_bits(32'hFFFF_FFFF, 17, got);
        clks(4);
        ss = 1'b0;
        clks(8);
        check("partial_no_write", 32'(writes_seen), 32'd0);
        check("partial_state_receive", 32'(state), 32'd1);
        send_sample(32'h0000_0001);
        send_sample(32'h0000_ABCD);
        send_sample(32'h0000_0200);
        send_sample(32'hFFFF_FFFF);
        check("f1_input_ready", 32'(input_ready), 32'd1);
        check("f1_state_process", 32'(state), 32'd2);
        send_sample(32'h0000_0003);
        check("f1_writes_saturated", 32'(writes_seen), 32'd4);
        load_result(32'h0000_1111);
        exchange(32'h0000_1111, 32);
        check("f1_confirmed_count", 32'(conf_seen), 32'd1);
        check("f1_input_ready_cleared", 32'(input_ready), 32'd0);

        // Frame 2: back-to-back words under one ss, then three retries before a match
        start_frame();
        push_write(0, 32'h0000_03FF);
        push_write(1, 32'h0000_0155);
        push_write(2, 32'h0000_0000);
        push_write(3, 32'h0000_0278);
        ss = 1'b1;
        clks(4);
        spi_bits(32'h0000_03FF, 32, got);
        spi_bits(32'h0000_0155, 32, got);
        spi_bits(32'hFFFF_FC00, 32, got);
        spi_bits(32'h1234_5678, 32, got);
        clks(4);
        ss = 1'b0;
        clks(8);
        check("f2_writes", 32'(writes_seen), 32'd8);
        check("f2_input_ready", 32'(input_ready), 32'd1);
        load_result(32'h0000_1111);
        exchange(32'h0000_1110, 32);
        exchange(32'h0000_1110, 32);
        exchange(32'h0000_1110, 32);
        exchange(32'h0000_1111, 32);
        check("f2_confirmed_count", 32'(conf_seen), 32'd2);
        check("f2_failed_count", 32'(fail_seen), 32'd0);

        // Frame 3: four mismatches, one of them a truncated echo
        start_frame();
        send_sample(32'hDEAD_BEEF);
        send_sample(32'h0000_0000);
        send_sample(32'h0000_03FE);
        send_sample(32'h8000_0201);
        load_result(32'h0000_BEEF);
        exchange(32'h0000_BEEE, 32);
        exchange(32'h0000_BEEF, 16);
        exchange(32'h0000_BEEE, 32);
        exchange(32'h0000_BEEE, 32);
        check("f3_failed_count", 32'(fail_seen), 32'd1);
        check("f3_confirmed_count", 32'(conf_seen), 32'd2);
        check("f3_input_ready_cleared", 32'(input_ready), 32'd0);

        // Frame 4: reset in the middle of a transmission
        start_frame();
        send_sample(32'h0000_0011);
        send_sample(32'h0000_0022);
        send_sample(32'h0000_0033);
        send_sample(32'h0000_0044);
        load_result(32'hC3C3_C3C3);
        ss = 1'b1;
        clks(4);
        spi_bits(32'h0, 6, got);
        clks(6);
        check("f4_tx_prefix", {26'd0, got[5:0]}, 32'h0000_0030);
        check("f4_sdo_before_reset", 32'(sdo), 32'd1);
        check("f4_state_transmit", 32'(state), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_sdo", 32'(sdo), 32'd0);
        check("async_rst_wr_en", 32'(wr_en), 32'd0);
        check("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("async_rst_wr_data", 32'(wr_data), 32'd0);
        check("async_rst_input_ready", 32'(input_ready), 32'd0);
        check("async_rst_confirmed", 32'(confirmed), 32'd0);
        check("async_rst_failed", 32'(failed), 32'd0);
        clks(3);
        reset = 1'b0;
        clks(4);
        // ss still high from the aborted frame: traffic must be ignored until a fresh ss rise
        spi_bits(32'hFFFF_FFFF, 8, got);
        clks(4);
        check("post_reset_state_idle", 32'(state), 32'd0);
        ss = 1'b0;
        clks(8);
        start_frame();
        send_sample(32'h0000_0005);
        check("post_reset_state_receive", 32'(state), 32'd1);
        check("total_writes", 32'(writes_seen), 32'd17);
        check("write_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("outcome_queue_drained", 32'(exp_out.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
